// File: rtl/ones_counter_pkg.sv
// ones_counter_pkg
//   Shared definitions for the pipelined ones counter:
//   - mode encodings for the per-word mode input
//   - per-stage control sideband (valid/mode/last) that travels with the sums
//   - elaboration helpers for the number of registered tree stages and latency
package ones_counter_pkg;

    localparam logic MODE_WORD  = 1'b0;
    localparam logic MODE_FRAME = 1'b1;

    typedef struct packed {
        logic valid;
        logic mode;
        logic last;
    } stage_ctrl_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Number of registered adder-tree stages.
    function automatic int tree_stages(input int log_bw, input int reg_every);
        return ceil_div(log_bw, reg_every);
    endfunction

    // Input register + registered tree stages + output/accumulate register.
    function automatic int pipe_latency(input int log_bw, input int reg_every);
        return tree_stages(log_bw, reg_every) + 2;
    endfunction

    // A level is registered every reg_every levels; the last level always is.
    function automatic bit level_registered(input int lvl, input int log_bw,
                                            input int reg_every);
        return (((lvl + 1) % reg_every) == 0) || (lvl == log_bw - 1);
    endfunction

    function automatic int count_registered(input int log_bw, input int reg_every);
        int n;
        n = 0;
        for (int i = 0; i < log_bw; i++) begin
            if (level_registered(i, log_bw, reg_every)) n++;
        end
        return n;
    endfunction

    localparam int DEFAULT_LAT = pipe_latency(5, 1);

endpackage

// File: rtl/ones_adder_level.sv
// ones_adder_level
//   One level of the popcount adder tree: PAIRS independent additions of two
//   IN_W-bit unsigned sums into (IN_W+1)-bit sums, no truncation.
//   Pair p adds slices 2p and 2p+1 of sum_in into slice p of sum_out.
// Ports:
//   clk      rising-edge clock (used only when REG=1)
//   rst      synchronous active-low clear of the output register
//   en       register load enable (pipeline advance)
//   sum_in   2*PAIRS packed IN_W-bit sums
//   sum_out  PAIRS packed (IN_W+1)-bit sums, registered when REG=1
module ones_adder_level #(
    parameter int PAIRS = 1,
    parameter int IN_W  = 1,
    parameter bit REG   = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [2*PAIRS*IN_W-1:0]     sum_in,
    output logic [PAIRS*(IN_W+1)-1:0]   sum_out
);

    logic [PAIRS*(IN_W+1)-1:0] sum_c;

    always_comb begin
        sum_c = '0;
        for (int p = 0; p < PAIRS; p++) begin
            sum_c[p*(IN_W+1) +: (IN_W+1)] =
                {1'b0, sum_in[(2*p)*IN_W +: IN_W]} +
                {1'b0, sum_in[(2*p+1)*IN_W +: IN_W]};
        end
    end

    if (REG) begin : g_reg
        logic [PAIRS*(IN_W+1)-1:0] sum_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                sum_q <= '0;
            end else if (en) begin
                sum_q <= sum_c;
            end
        end

        assign sum_out = sum_q;
    end else begin : g_comb
        // Combinational level: clock, clear and enable have no role here.
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, rst, en};
        assign sum_out     = sum_c;
    end

endmodule

// File: rtl/ones_counter_pipe.sv
// ones_counter_pipe
//   Pipelined popcount of a 2**LOG_BIT_WIDTH-bit word with valid/ready on
//   both sides and an optional frame-accumulate mode.
//   Pipeline: input register -> adder tree (registered every REG_EVERY levels,
//   last level always) -> output/accumulate register. Latency with no stall
//   is tree_stages + 2 cycles.
//   Handshake: a transfer happens on any edge where valid && ready. The whole
//   pipeline moves together on advance = !out_valid || out_ready; in_ready is
//   advance, so it depends only on out_valid/out_ready. While advance is low
//   every stage and the outputs hold. Empty stages travel as bubbles.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   in_valid/in_ready        input handshake for word_in, in_last, mode
//   word_in                  word to count
//   in_last                  closes a frame (mode 1 only)
//   mode                     0 = per-word count, 1 = frame accumulate
//   out_valid/out_ready      output handshake
//   count_out                popcount or saturated frame total
//   acc_ovf                  frame total clamped (mode-1 results only)
module ones_counter_pipe
    import ones_counter_pkg::*;
#(
    parameter int LOG_BIT_WIDTH = 5,
    parameter int REG_EVERY     = 1,
    parameter int ACC_WIDTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2**LOG_BIT_WIDTH-1:0] word_in,
    input  logic                        in_last,
    input  logic                        mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH-1:0]        count_out,
    output logic                        acc_ovf
);

    localparam int W     = 2**LOG_BIT_WIDTH;
    localparam int S     = tree_stages(LOG_BIT_WIDTH, REG_EVERY);
    localparam int SUM_W = LOG_BIT_WIDTH + 1;

    if (ACC_WIDTH < LOG_BIT_WIDTH + 1) begin : g_bad_acc_width
        $error("ACC_WIDTH must be at least LOG_BIT_WIDTH+1");
    end
    if (REG_EVERY < 1 || REG_EVERY > LOG_BIT_WIDTH) begin : g_bad_reg_every
        $error("REG_EVERY must lie in 1..LOG_BIT_WIDTH");
    end
    if (count_registered(LOG_BIT_WIDTH, REG_EVERY) != S) begin : g_bad_stage_count
        $error("registered tree level count disagrees with tree_stages");
    end

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Input register.
    logic [W-1:0] word_q;
    stage_ctrl_t  ctrl_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_q <= '0;
            ctrl_q <= '0;
        end else if (advance) begin
            word_q <= word_in;
            ctrl_q <= {in_valid, mode, in_last};
        end
    end

    // Adder tree. Level j turns W>>j sums of (j+1) bits into W>>(j+1) sums of
    // (j+2) bits; the control sideband is registered wherever the sums are.
    for (genvar j = 0; j < LOG_BIT_WIDTH; j++) begin : g_lvl
        localparam int PAIRS = W >> (j + 1);
        localparam int IN_W  = j + 1;
        localparam bit REG   = level_registered(j, LOG_BIT_WIDTH, REG_EVERY);

        logic [2*PAIRS*IN_W-1:0]   sum_in;
        logic [PAIRS*(IN_W+1)-1:0] sum_out;
        stage_ctrl_t               ctrl_in;
        stage_ctrl_t               ctrl_out;

        if (j == 0) begin : g_first
            assign sum_in  = word_q;
            assign ctrl_in = ctrl_q;
        end else begin : g_next
            assign sum_in  = g_lvl[j-1].sum_out;
            assign ctrl_in = g_lvl[j-1].ctrl_out;
        end

        ones_adder_level #(
            .PAIRS (PAIRS),
            .IN_W  (IN_W),
            .REG   (REG)
        ) u_level (
            .clk     (clk),
            .rst     (rst),
            .en      (advance),
            .sum_in  (sum_in),
            .sum_out (sum_out)
        );

        if (REG) begin : g_ctrl_reg
            stage_ctrl_t ctrl_r;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    ctrl_r <= '0;
                end else if (advance) begin
                    ctrl_r <= ctrl_in;
                end
            end

            assign ctrl_out = ctrl_r;
        end else begin : g_ctrl_pass
            assign ctrl_out = ctrl_in;
        end
    end

    stage_ctrl_t          fin_ctrl;
    logic [SUM_W-1:0]     fin_sum;
    logic [ACC_WIDTH-1:0] pc_ext;

    assign fin_ctrl = g_lvl[LOG_BIT_WIDTH-1].ctrl_out;
    assign fin_sum  = g_lvl[LOG_BIT_WIDTH-1].sum_out;
    assign pc_ext   = ACC_WIDTH'(fin_sum);

    // Frame accumulator with saturation; the extra carry bit flags a clamp.
    logic [ACC_WIDTH-1:0] acc;
    logic                 acc_sticky;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 clamp;
    logic [ACC_WIDTH-1:0] acc_sat;

    assign acc_sum = {1'b0, acc} + {1'b0, pc_ext};
    assign clamp   = acc_sum[ACC_WIDTH];
    assign acc_sat = clamp ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];

    // Output/accumulate register. Mode-0 words leave the accumulator alone so
    // they may be interleaved inside an open frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            count_out  <= '0;
            acc_ovf    <= 1'b0;
            acc        <= '0;
            acc_sticky <= 1'b0;
        end else if (advance) begin
            out_valid <= 1'b0;
            if (fin_ctrl.valid) begin
                if (fin_ctrl.mode == MODE_WORD) begin
                    out_valid <= 1'b1;
                    count_out <= pc_ext;
                    acc_ovf   <= 1'b0;
                end else if (fin_ctrl.last) begin
                    out_valid  <= 1'b1;
                    count_out  <= acc_sat;
                    acc_ovf    <= acc_sticky | clamp;
                    acc        <= '0;
                    acc_sticky <= 1'b0;
                end else begin
                    acc        <= acc_sat;
                    acc_sticky <= acc_sticky | clamp;
                end
            end
        end
    end

endmodule

// File: doc/ones_counter_pipe.md
Name: ones_counter_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle ones counter: a binary adder-tree popcount of a 2**LOG_BIT_WIDTH-bit word.
- Adds configurable pipeline-register insertion inside the tree and valid/ready handshakes on both sides.
- Adds an accumulate mode that sums popcounts over a multi-word frame.
- Sits between a word-stream producer and statistics/compare logic that may stall.

Parameters:
- LOG_BIT_WIDTH, 5, log2 of input word width W = 2**LOG_BIT_WIDTH.
- REG_EVERY, 1, pipeline register after every REG_EVERY adder-tree levels; final level is always registered. Legal range 1..LOG_BIT_WIDTH.
- ACC_WIDTH, 16, accumulator/result width. Must be >= LOG_BIT_WIDTH+1; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  word_in/in_last/mode valid
- in_ready  out  1  block can accept this cycle
- word_in  in  W  word to count
- in_last  in  1  last word of frame (mode 1 only)
- mode  in  1  0 = per-word count, 1 = frame accumulate; sampled per word
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- count_out  out  ACC_WIDTH  popcount or frame total, zero-extended
- acc_ovf  out  1  frame total saturated (mode 1 results only)

Behaviour:
- Reset (rst==0 at a clk edge): all stage valids, out_valid, count_out, acc_ovf and the accumulator clear to 0 on that edge. In-flight words are dropped. A partial frame is discarded.
- Stages:
  - Input register (word, mode, last, valid).
  - S = ceil(LOG_BIT_WIDTH/REG_EVERY) registered tree stages.
  - Output/accumulate register.
- Latency: LAT = S+2 cycles from an accepted word to its result with no stall. Defaults give LAT = 7; REG_EVERY = LOG_BIT_WIDTH gives LAT = 3.
- Tree: level k adds pairs of k-bit sums into (k+1)-bit sums, unsigned, no truncation. The final sum is LOG_BIT_WIDTH+1 bits, max W.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance. in_ready is combinational from out_ready and out_valid only, never from in_valid.
  - Transfer on in_valid && in_ready.
  - When advance==0, every stage holds, and count_out/acc_ovf/out_valid stay stable.
  - Bubbles propagate as invalid stages and are not collapsed.
  - Results appear in acceptance order.
- Mode 0:
  - Every valid word produces one result: count_out = popcount, acc_ovf = 0.
  - The accumulator is untouched, so mode-0 words may interleave inside a mode-1 frame.
- Mode 1:
  - A word without in_last updates acc <= sat(acc + popcount) and produces no output.
  - A word with in_last outputs count_out = sat(acc + popcount) and acc_ovf = frame-sticky overflow. acc and the sticky flag then clear.
  - A single-word frame (in_last on its first word) is legal.
- Saturation: sat clamps to 2**ACC_WIDTH-1. The sticky overflow flag sets on any clamp within the frame.
- Simultaneous final-stage output handoff and accumulator update in the same advancing cycle are legal; the accumulator update uses only the stage's own word.
- in_last is ignored in mode 0.

Decomposition:
- Shared package ones_counter_pkg holds:
  - function clog/ceil-div for S
  - localparam computation of LAT
  - mode encodings MODE_WORD = 0, MODE_FRAME = 1
- Sub-module ones_adder_level:
  - one tree level
  - parameters: pair count and input width
  - optional output register with enable and sync active-low clear
  - instantiated LOG_BIT_WIDTH times by a generate loop

Test Plan:
1. Mode 0, word_in=0xFFFFFFFF, out_ready=1 -> out_valid high exactly 7 cycles later for one cycle, count_out=32, acc_ovf=0.
2. Back-to-back mode 0 words 0x00000000, 0x00000001, 0x80000001, 0xAAAAAAAA -> results 0, 1, 2, 16 on consecutive cycles, in order.
3. Full pipeline, out_ready low for 3 cycles -> in_ready low those cycles, count_out held stable, no result lost or duplicated after release.
4. Mode 1 frame 0xFFFFFFFF, 0x0000000F, 0x00000001(last) -> single result 37, acc_ovf=0. A following one-word frame 0x3 gives 2.
5. ACC_WIDTH=6, mode 1 frame of three 0xFFFFFFFF words (total 96) -> count_out=63, acc_ovf=1. The next frame 0x1(last) gives 1, acc_ovf=0.
6. rst low for one cycle mid-frame with 4 words in flight -> out_valid=0 after that edge, no stale results. A new frame 0xF(last) gives 4.
